// File: rtl/musa_pkg.sv
// Shared core definitions: bus widths, memory-arbiter FSM encoding and the
// default access timing used by the memory arbiter.
package musa_pkg;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  // Memory cycles per access; legal range 1..15 so the wait counter fits CNT_W.
  localparam int unsigned WAIT_STATES_DEFAULT = 1;
  localparam int          CNT_W               = 4;

  // Consecutive data grants tolerated while a fetch waits before fetch is forced.
  localparam int                  STREAK_W   = 2;
  localparam logic [STREAK_W-1:0] STREAK_MAX = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] s);
    return (s == STREAK_MAX) ? s : s + STREAK_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Data normally wins; a saturating streak counter forces a fetch after three data grants.
module mem_arbiter
  import musa_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [XLEN-1:0]   d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

  arb_state_e          state_q,    state_d;
  owner_e              owner_q,    owner_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [STREAK_W-1:0] streak_q,   streak_d;
  logic                we_q,       we_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic [XLEN-1:0]     wdata_q,    wdata_d;
  logic                if_gnt_q,   if_gnt_d;
  logic                d_gnt_q,    d_gnt_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q,  d_valid_d;
  logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]     d_rdata_q,  d_rdata_d;
  logic                fetch_wins;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_gnt_d   = 1'b0;
    d_gnt_d    = 1'b0;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    fetch_wins = if_req && (!d_req || streak_q == STREAK_MAX);

    unique case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d = ST_ACCESS;
          cnt_d   = CNT_LOAD;
          if (fetch_wins) begin
            owner_d  = OWN_FETCH;
            we_d     = 1'b0;
            addr_d   = if_addr;
            if_gnt_d = 1'b1;
            streak_d = '0;
          end else begin
            owner_d  = OWN_DATA;
            we_d     = d_we;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            d_gnt_d  = 1'b1;
            // Only count data grants that actually made a fetch wait.
            streak_d = if_req ? streak_inc(streak_q) : '0;
          end
        end
      end

      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!we_q) d_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_FETCH;
      cnt_q      <= '0;
      streak_q   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_gnt_q   <= 1'b0;
      d_gnt_q    <= 1'b0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_gnt_q   <= if_gnt_d;
      d_gnt_q    <= d_gnt_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  // The memory port is live exactly while in ACCESS; write enable is gated by it.
  assign mem_en    = (state_q == ST_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed fetch/load/store/priority/reset scenarios
// on a WAIT_STATES=1 instance, plus a WAIT_STATES=3 instance for store timing.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WAIT_STATES = 1 instance
  logic        if_req1, d_req1, d_we1;
  logic [31:0] if_addr1, d_addr1, d_wdata1;
  logic        if_gnt1, if_valid1, d_gnt1, d_valid1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

  // WAIT_STATES = 3 instance
  logic        if_req3, d_req3, d_we3;
  logic [31:0] if_addr3, d_addr3, d_wdata3;
  logic        if_gnt3, if_valid3, d_gnt3, d_valid3, mem_en3, mem_we3;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_data;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0010: return 32'h8C22_0004;
      32'h0000_0040: return 32'h0000_1234;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Read data is only meaningful while the port is enabled.
  assign mem_rdata1 = mem_en1 ? mem_model(mem_addr1) : 32'hBAD0_BAD0;
  assign mem_rdata3 = mem_en3 ? mem_model(mem_addr3) : 32'hBAD0_BAD0;

  mem_arbiter #(.WAIT_STATES(1)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_valid(if_valid1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_gnt(d_gnt1), .d_valid(d_valid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1)
  );

  mem_arbiter #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_valid(if_valid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_valid(d_valid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input bit is_data, input logic [31:0] data);
    exp_t e;
    e.is_data = is_data;
    e.data    = data;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the chosen grant, then withdraws that request.
  task automatic wait_gnt(input bit is_data, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!(is_data ? d_gnt1 : if_gnt1) && n < 20);
    check(name, 32'(is_data ? d_gnt1 : if_gnt1), 32'd1);
    if (is_data) d_req1 = 1'b0;
    else         if_req1 = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  // Monitor for the WAIT_STATES=1 instance: pops expectations on each valid pulse.
  always @(negedge clk) begin
    if (reset) begin
      if (if_gnt1 || d_gnt1) check("gnt_exclusive", 32'(if_gnt1 && d_gnt1), 32'd0);
      if (if_valid1 || d_valid1) begin
        check("valid_exclusive", 32'(if_valid1 && d_valid1), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got if_valid=%0b d_valid=%0b, required no pulse at %0t",
                   if_valid1, d_valid1, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("valid_port", 32'(d_valid1), 32'(e.is_data));
          check("rdata", e.is_data ? d_rdata1 : if_rdata1, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n;
    int last;
    bit exp_kind[4];

    reset   = 1'b0;
    if_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0;
    if_addr1 = '0;  d_addr1 = '0;  d_wdata1 = '0;
    if_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0;
    if_addr3 = '0;  d_addr3 = '0;  d_wdata3 = '0;
    repeat (3) step();

    // Reset state
    check("rst_gnt",      32'({if_gnt1, d_gnt1}), 32'd0);
    check("rst_valid",    32'({if_valid1, d_valid1}), 32'd0);
    check("rst_mem_en",   32'({mem_en1, mem_we1}), 32'd0);
    check("rst_mem_addr", mem_addr1, 32'd0);
    check("rst_mem_wdata", mem_wdata1, 32'd0);
    check("rst_if_rdata", if_rdata1, 32'd0);
    check("rst_d_rdata",  d_rdata1, 32'd0);
    check("rst3_mem_en",  32'(mem_en3), 32'd0);
    reset = 1'b1;
    step();

    // Fetch only: gnt at N+1, valid at N+2
    if_req1 = 1'b1; if_addr1 = 32'h10;
    push(1'b0, 32'h8C22_0004);
    step();
    check("a_if_gnt",   32'(if_gnt1), 32'd1);
    check("a_d_gnt",    32'(d_gnt1), 32'd0);
    check("a_mem_en",   32'(mem_en1), 32'd1);
    check("a_mem_we",   32'(mem_we1), 32'd0);
    check("a_mem_addr", mem_addr1, 32'h10);
    if_req1 = 1'b0;
    step();
    check("a_if_valid", 32'(if_valid1), 32'd1);
    check("a_idle_en",  32'(mem_en1), 32'd0);
    check("a_addr_hold", mem_addr1, 32'h10);

    // Simultaneous fetch and load: data first, fetch granted from the d_valid cycle
    if_req1 = 1'b1; if_addr1 = 32'h14;
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h40;
    push(1'b1, 32'h0000_1234);
    push(1'b0, 32'hA5A5_0014);
    step();
    check("b_d_gnt_first", 32'(d_gnt1), 32'd1);
    check("b_if_gnt_wait", 32'(if_gnt1), 32'd0);
    d_req1 = 1'b0;
    step();
    check("b_d_valid",     32'(d_valid1), 32'd1);
    check("b_if_gnt_wait2", 32'(if_gnt1), 32'd0);
    step();
    check("b_if_gnt",      32'(if_gnt1), 32'd1);
    check("b_if_mem_addr", mem_addr1, 32'h14);
    if_req1 = 1'b0;
    step();
    check("b_if_valid",    32'(if_valid1), 32'd1);

    // Held data requests with fetch waiting: D, D, D, then F
    exp_kind = '{1'b1, 1'b1, 1'b1, 1'b0};
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h100;
    if_req1 = 1'b1; if_addr1 = 32'h200;
    push(1'b1, 32'hA5A5_0100);
    push(1'b1, 32'hA5A5_0104);
    push(1'b1, 32'hA5A5_0108);
    push(1'b0, 32'hA5A5_0200);
    k = 0; n = 0; last = 0;
    while (k < 4 && n < 30) begin
      step();
      n++;
      if (d_gnt1 || if_gnt1) begin
        check($sformatf("c_grant_kind_%0d", k), 32'(d_gnt1), 32'(exp_kind[k]));
        if (k > 0) check($sformatf("c_grant_gap_%0d", k), 32'(n - last), 32'd2);
        last = n;
        if (d_gnt1) d_addr1 = d_addr1 + 32'd4;
        if (if_gnt1) begin
          if_req1 = 1'b0;
          d_req1  = 1'b0;
        end
        k++;
      end
    end
    check("c_grant_count", 32'(k), 32'd4);
    step();

    // Streak cleared by the fetch grant: data wins again
    d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h300;
    if_req1 = 1'b1; if_addr1 = 32'h304;
    push(1'b1, 32'hA5A5_0300);
    push(1'b0, 32'hA5A5_0304);
    step();
    check("c_streak_clear_d_gnt", 32'(d_gnt1), 32'd1);
    d_req1 = 1'b0;
    wait_gnt(1'b0, "c_followup_if_gnt");
    drain("c_drain");

    // Store on the WS=1 instance keeps d_rdata from the previous load
    d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 32'h24; d_wdata1 = 32'h1357_9BDF;
    push(1'b1, 32'hA5A5_0300);
    step();
    check("s1_mem_we",    32'(mem_we1), 32'd1);
    check("s1_mem_wdata", mem_wdata1, 32'h1357_9BDF);
    d_req1 = 1'b0;
    drain("s1_drain");
    check("s1_idle_we",   32'(mem_we1), 32'd0);
    d_we1 = 1'b0;

    // Reset in the middle of the third data access
    d_req1 = 1'b1; d_addr1 = 32'h400;
    if_req1 = 1'b1; if_addr1 = 32'h500;
    push(1'b1, 32'hA5A5_0400);
    push(1'b1, 32'hA5A5_0404);
    k = 0; n = 0;
    while (k < 3 && n < 30) begin
      step();
      n++;
      if (d_gnt1) begin
        k++;
        if (k < 3) d_addr1 = d_addr1 + 32'd4;
      end
    end
    check("e_three_d_gnt", 32'(k), 32'd3);
    reset = 1'b0;
    step();
    check("e_rst_mem_en",  32'(mem_en1), 32'd0);
    check("e_rst_d_valid", 32'(d_valid1), 32'd0);
    check("e_rst_gnt",     32'({if_gnt1, d_gnt1}), 32'd0);
    check("e_rst_d_rdata", d_rdata1, 32'd0);
    d_req1 = 1'b0; if_req1 = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("e_no_valid_after", 32'(d_valid1), 32'd0);
    check("e_sb_after_rst",  32'(sb.size()), 32'd0);

    // Streak was cleared by reset: data wins over fetch
    d_req1 = 1'b1; d_addr1 = 32'h600;
    if_req1 = 1'b1; if_addr1 = 32'h604;
    push(1'b1, 32'hA5A5_0600);
    push(1'b0, 32'hA5A5_0604);
    step();
    check("e_post_rst_d_gnt", 32'(d_gnt1), 32'd1);
    d_req1 = 1'b0;
    wait_gnt(1'b0, "e_post_rst_if_gnt");
    drain("e_drain");

    // WAIT_STATES=3: load then store, valid at N+4, mem_we for 3 cycles
    d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h40;
    step();
    check("d3_load_gnt", 32'(d_gnt3), 32'd1);
    d_req3 = 1'b0;
    repeat (2) step();
    check("d3_load_no_early_valid", 32'(d_valid3), 32'd0);
    step();
    check("d3_load_valid", 32'(d_valid3), 32'd1);
    check("d3_load_rdata", d_rdata3, 32'h0000_1234);
    d_req3 = 1'b1; d_we3 = 1'b1; d_addr3 = 32'h20; d_wdata3 = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1) begin
        check("d3_store_gnt", 32'(d_gnt3), 32'd1);
        d_req3 = 1'b0;
        d_we3  = 1'b0;
      end
      check($sformatf("d3_store_en_we_c%0d", c), 32'({mem_en3, mem_we3}), 32'd3);
      check($sformatf("d3_store_addr_c%0d", c), mem_addr3, 32'h20);
      check($sformatf("d3_store_wdata_c%0d", c), mem_wdata3, 32'hDEAD_BEEF);
      check($sformatf("d3_store_valid_c%0d", c), 32'(d_valid3), 32'd0);
    end
    step();
    check("d3_store_valid",  32'(d_valid3), 32'd1);
    check("d3_store_idle",   32'({mem_en3, mem_we3}), 32'd0);
    check("d3_store_rdata",  d_rdata3, 32'h0000_1234);
    check("d3_if_quiet",     32'({if_gnt3, if_valid3}), 32'd0);
    check("d3_if_rdata",     if_rdata3, 32'd0);
    step();
    check("d3_valid_pulse",  32'(d_valid3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, memory cycles per access (legal 1..15).
REQ-002 SHALL have clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have if_req  input  1  instruction-fetch request, held high until if_gnt.
REQ-005 SHALL have if_addr  input  32  fetch word address.
REQ-006 SHALL have if_gnt  output  1  one-cycle pulse, fetch request accepted.
REQ-007 SHALL have if_valid  output  1  one-cycle pulse, if_rdata valid.
REQ-008 SHALL have if_rdata  output  32  fetched instruction.
REQ-009 SHALL have d_req  input  1  data-access request (load/store), held high until d_gnt.
REQ-010 SHALL have d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have d_addr  input  32  data address.
REQ-012 SHALL have d_wdata  input  32  store data.
REQ-013 SHALL have d_gnt  output  1  one-cycle pulse, data request accepted.
REQ-014 SHALL have d_valid  output  1  one-cycle pulse, load data valid or store complete.
REQ-015 SHALL have d_rdata  output  32  load data.
REQ-016 SHALL have mem_en  output  1  memory access enable.
REQ-017 SHALL have mem_we  output  1  memory write enable, never high while mem_en low.
REQ-018 SHALL have mem_addr  output  32  memory address.
REQ-019 SHALL have mem_wdata  output  32  memory write data.
REQ-020 SHALL have mem_rdata  input  32  memory read data, valid in the last ACCESS cycle.

Function
REQ-021 SHALL implement FSM states IDLE and ACCESS only.
REQ-022 In IDLE with any request high, SHALL choose a winner, pulse its gnt, latch its addr/we/wdata and owner bit, load wait counter with WAIT_STATES-1, and enter ACCESS on the next edge.
REQ-023 Gnt SHALL be registered: high exactly during the first ACCESS cycle.
REQ-024 Priority: data over fetch, except when a 2-bit streak counter equals 3, in which case fetch wins.
REQ-025 Streak SHALL increment (saturating at 3) on each data grant made while if_req was high, and clear on every fetch grant or data grant with if_req low.
REQ-026 In ACCESS, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL hold latched values; counter decrements each cycle.
REQ-027 When ACCESS counter is 0, SHALL register mem_rdata into owner's rdata, pulse owner's valid on the next cycle, and return to IDLE.
REQ-028 Latency: gnt at cycle N+1, valid at cycle N+1+WAIT_STATES for a request first seen in IDLE at cycle N.
REQ-029 A request arriving during ACCESS SHALL wait; SHALL be granted from IDLE on the cycle valid of the previous access is high (back-to-back throughput one access per WAIT_STATES+1 cycles).
REQ-030 In IDLE, mem_en, mem_we SHALL be 0; mem_addr/mem_wdata SHALL hold last values.
REQ-031 Non-owner rdata SHALL hold its previous value; for stores, d_rdata SHALL be unchanged.
REQ-032 At most one of if_gnt, d_gnt and at most one of if_valid, d_valid SHALL be high in any cycle.

Reset
REQ-033 With reset low at a clock edge: state IDLE, all gnt/valid/mem_en/mem_we 0, rdata/mem_addr/mem_wdata 0, streak 0, counter 0.
REQ-034 Reset during ACCESS SHALL abandon the access with no valid pulse; requester re-requests.

Structure
REQ-035 FSM state encoding, WAIT_STATES default and data/address width constants SHALL live in the shared core package (musa_pkg).
REQ-036 No sub-module; priority selection and streak counter inline.

Verification
REQ-037 Fetch only, WAIT_STATES=1, if_addr=0x10, mem_rdata=0x8C220004 -> if_gnt at N+1, if_valid at N+2, if_rdata=0x8C220004.
REQ-038 Simultaneous if_req and d_req (load 0x40) -> d_gnt first, then if_gnt on d_valid cycle; never both gnts together.
REQ-039 d_req held continuously with if_req high -> three data grants then one fetch grant; streak clears.
REQ-040 Store d_addr=0x20, d_wdata=0xDEADBEEF, WAIT_STATES=3 -> mem_we=mem_en=1 for 3 cycles, mem_addr=0x20, d_valid at N+4, d_rdata unchanged.
REQ-041 Reset low mid-ACCESS -> next cycle mem_en=0, no valid pulse, streak 0; new request served normally after reset release.
